// File: rtl/alu_input_sequencer_if.sv
// Board-side bundle for the ALU input sequencer: switch/button inputs toward
// the sequencer and the registered result, flags and state coming back.
interface alu_input_sequencer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_BTN  = 4
);
  logic [NB_DATA-1:0] i_sw;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_DATA-1:0] o_led;
  logic [2:0]         o_flags;
  logic [1:0]         o_state;
  logic               o_valid;

  // Board / stimulus side
  modport master (
    output i_sw, i_btn,
    input  o_led, o_flags, o_state, o_valid
  );

  // Sequencer side
  modport slave (
    input  i_sw, i_btn,
    output o_led, o_flags, o_state, o_valid
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Operand-entry and execution controller for the board ALU path.
// Buttons are synchronised, optionally debounced (build macro DEBOUNCE_EN)
// and edge detected into one-cycle commands. A small FSM loads A, B and the
// opcode from the switches and runs a registered ALU operation on execute.
// Without DEBOUNCE_EN the synchroniser feeds the edge detector directly and
// DEBOUNCE_CYCLES has no effect.
module alu_input_sequencer #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int NB_BTN          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                  clock,
  input logic                  i_reset,
  alu_input_sequencer_if.slave bus
);

  localparam int MSB = NB_DATA - 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_EXEC  = 2'b10;
  localparam logic [1:0] ST_HOLD  = 2'b11;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  // Returns {overflow, carry, result}. Undefined opcodes yield all zeros.
  function automatic logic [NB_DATA+1:0] alu_eval(
    input logic [NB_DATA-1:0] a,
    input logic [NB_DATA-1:0] b,
    input logic [NB_OP-1:0]   op
  );
    logic [NB_DATA:0]          wide;
    logic [NB_DATA-1:0]        res;
    logic signed [NB_DATA-1:0] sa;
    logic signed [NB_DATA-1:0] sres;
    logic [31:0]               shamt;
    logic                      carry;
    logic                      ovf;
    wide  = '0;
    res   = '0;
    sa    = $signed(a);
    sres  = '0;
    shamt = 32'(b);
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[NB_DATA-1:0];
        carry = wide[NB_DATA];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Bit NB_DATA of the widened difference is the unsigned borrow.
        wide  = {1'b0, a} - {1'b0, b};
        res   = wide[NB_DATA-1:0];
        carry = wide[NB_DATA];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRL: begin
        if (shamt >= 32'(NB_DATA)) res = '0;
        else                       res = a >> b;
      end
      OP_SRA: begin
        if (shamt >= 32'(NB_DATA)) begin
          res = {NB_DATA{a[MSB]}};
        end else begin
          sres = sa >>> b;
          res  = sres;
        end
      end
      default: res = '0;
    endcase
    return {ovf, carry, res};
  endfunction

  logic [NB_BTN-1:0]  sync_p0;
  logic [NB_BTN-1:0]  sync_p1;
  logic [NB_BTN-1:0]  level;
  logic [NB_BTN-1:0]  level_q;
  logic [NB_BTN-1:0]  cmd_p2;

  logic               load_a;
  logic               load_b;
  logic               load_op;
  logic               exec_cmd;
  logic               any_load;

  logic [NB_DATA-1:0] opa;
  logic [NB_DATA-1:0] opb;
  logic [NB_OP-1:0]   opcode;

  logic [1:0]         state;
  logic [NB_DATA-1:0] led_q;
  logic [2:0]         flags_q;
  logic               valid_q;
  logic [NB_DATA+1:0] alu_out;

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous buttons ----
  // Bring the raw buttons into the clock domain
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.i_btn;
      sync_p1 <= sync_p0;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]  db_cnt [NB_BTN];
  logic [NB_BTN-1:0] db_level;

  // Accept a new level only after it has persisted; any reversion restarts
  always_ff @(posedge clock) begin
    if (i_reset) begin
      db_level <= '0;
      for (int i = 0; i < NB_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB_BTN; i++) begin
        if (sync_p1[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_level[i] <= sync_p1[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync_p1;
`endif

  // ---- stage p2: rising-edge detect into one-cycle command pulses ----
  // A held button produces a single pulse on its rising edge
  always_ff @(posedge clock) begin
    if (i_reset) begin
      level_q <= '0;
      cmd_p2  <= '0;
    end else begin
      level_q <= level;
      cmd_p2  <= level & ~level_q;
    end
  end

  // Fixed priority: load A > load B > load opcode > execute
  always_comb begin
    load_a   = cmd_p2[0];
    load_b   = cmd_p2[1] & ~cmd_p2[0];
    load_op  = cmd_p2[2] & ~|cmd_p2[1:0];
    exec_cmd = cmd_p2[3] & ~|cmd_p2[2:0];
    any_load = |cmd_p2[2:0];
  end

  // Operand registers capture the switches; commands during EXEC are dropped
  always_ff @(posedge clock) begin
    if (i_reset) begin
      opa    <= '0;
      opb    <= '0;
      opcode <= '0;
    end else if (state != ST_EXEC) begin
      if (load_a)  opa    <= bus.i_sw;
      if (load_b)  opb    <= bus.i_sw;
      if (load_op) opcode <= bus.i_sw[NB_OP-1:0];
    end
  end

  assign alu_out = alu_eval(opa, opb, opcode);

  // ---- stage p3: sequencing FSM and registered result/flags ----
  // Result and flags are only written in EXEC; a load in HOLD invalidates them
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      led_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_load) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!any_load && exec_cmd) state <= ST_EXEC;
        end
        ST_EXEC: begin
          led_q   <= alu_out[NB_DATA-1:0];
          flags_q <= {alu_out[NB_DATA+1], alu_out[NB_DATA],
                      (alu_out[NB_DATA-1:0] == '0)};
          valid_q <= 1'b1;
          state   <= ST_HOLD;
        end
        default: begin
          if (any_load) begin
            valid_q <= 1'b0;
            state   <= ST_ARMED;
          end else if (exec_cmd) begin
            state <= ST_EXEC;
          end
        end
      endcase
    end
  end

  assign bus.o_led   = led_q;
  assign bus.o_flags = flags_q;
  assign bus.o_state = state;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: directed vector table,
// hand-written multi-cycle sequences and a randomized run against an
// operation-level reference model. Honours DEBOUNCE_EN (DEBOUNCE_CYCLES=4).
module tb_alu_input_sequencer;
  localparam int NB_DATA  = 8;
  localparam int NB_OP    = 6;
  localparam int NB_BTN   = 4;
  localparam int DB       = 4;
  localparam int HOLD_CYC = DB + 6;
  localparam int SETTLE   = DB + 8;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  logic clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 clock = ~clock;

  alu_input_sequencer_if #(.NB_DATA(NB_DATA), .NB_BTN(NB_BTN)) bus();

  alu_input_sequencer #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_BTN(NB_BTN), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .i_reset(i_reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] led;
    logic [2:0] flags;
  } vec_t;

  vec_t vecs[$];

  // operation-level model state
  int         m_a, m_b, m_op, m_led, m_state;
  logic [2:0] m_flags;
  logic       m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] led, input logic [2:0] flags,
                           input logic valid, input logic [1:0] st);
    check({name, ".led"},   32'(bus.o_led),   32'(led));
    check({name, ".flags"}, 32'(bus.o_flags), 32'(flags));
    check({name, ".valid"}, 32'(bus.o_valid), 32'(valid));
    check({name, ".state"}, 32'(bus.o_state), 32'(st));
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    bus.i_btn  = '0;
    bus.i_sw   = '0;
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic press(input logic [3:0] mask, input logic [7:0] sw);
    @(posedge clock);
    #1;
    bus.i_sw  = sw;
    bus.i_btn = mask;
    repeat (HOLD_CYC) @(posedge clock);
    #1 bus.i_btn = '0;
    repeat (SETTLE) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    press(4'b0001, a);
    press(4'b0010, b);
    press(4'b0100, {2'b00, op});
    press(4'b1000, 8'h00);
  endtask

  // Reference ALU from the arithmetic definitions, using plain integers
  function automatic void model_alu(input int a, input int b, input int op,
                                    output int led, output logic [2:0] flags);
    int sa, sb, r;
    logic c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; r = 0;
    case (op)
      32'(OP_ADD): begin r = a + b; c = (r >= 256); v = (sa + sb > 127) || (sa + sb < -128); r = r % 256; end
      32'(OP_SUB): begin r = (a - b + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
      32'(OP_AND): r = a & b;
      32'(OP_OR):  r = a | b;
      32'(OP_XOR): r = a ^ b;
      32'(OP_NOR): r = 255 - (a | b);
      32'(OP_SRL): r = (b >= 8) ? 0 : a / (1 << b);
      32'(OP_SRA): r = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      default:     r = 0;
    endcase
    led = r;
    flags = {v, c, (r == 0)};
  endfunction

  task automatic model_cmd(input int btn, input int sw);
    if (btn < 3) begin
      if (btn == 0) m_a = sw;
      else if (btn == 1) m_b = sw;
      else m_op = sw % 64;
      m_state = 1;
      m_valid = 0;
    end else if (m_state != 0) begin
      model_alu(m_a, m_b, m_op, m_led, m_flags);
      m_valid = 1;
      m_state = 3;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    logic [7:0] exp_a;

    vecs.push_back('{"add_ovf",   8'h7F, 8'h01, OP_ADD, 8'h80, 3'b100});
    vecs.push_back('{"add_carry", 8'hFF, 8'h01, OP_ADD, 8'h00, 3'b011});
    vecs.push_back('{"add_plain", 8'h12, 8'h34, OP_ADD, 8'h46, 3'b000});
    vecs.push_back('{"sub_zero",  8'h05, 8'h05, OP_SUB, 8'h00, 3'b001});
    vecs.push_back('{"sub_borrow",8'h03, 8'h05, OP_SUB, 8'hFE, 3'b010});
    vecs.push_back('{"sub_ovf",   8'h80, 8'h01, OP_SUB, 8'h7F, 3'b100});
    vecs.push_back('{"and",       8'hF0, 8'h3C, OP_AND, 8'h30, 3'b000});
    vecs.push_back('{"or",        8'hF0, 8'h0F, OP_OR,  8'hFF, 3'b000});
    vecs.push_back('{"xor_zero",  8'hAA, 8'hAA, OP_XOR, 8'h00, 3'b001});
    vecs.push_back('{"nor",       8'h0F, 8'h30, OP_NOR, 8'hC0, 3'b000});
    vecs.push_back('{"sra_big",   8'h80, 8'h09, OP_SRA, 8'hFF, 3'b000});
    vecs.push_back('{"srl_big",   8'h80, 8'h09, OP_SRL, 8'h00, 3'b001});
    vecs.push_back('{"sra_1",     8'h80, 8'h01, OP_SRA, 8'hC0, 3'b000});
    vecs.push_back('{"srl_4",     8'hF0, 8'h04, OP_SRL, 8'h0F, 3'b000});
    vecs.push_back('{"srl_eq_w",  8'h81, 8'h08, OP_SRL, 8'h00, 3'b001});
    vecs.push_back('{"sra_eq_w",  8'h7F, 8'h08, OP_SRA, 8'h00, 3'b001});
    vecs.push_back('{"undef",     8'h12, 8'h34, 6'b111111, 8'h00, 3'b001});

    // Reset state, and execute ignored in IDLE
    bus.i_btn = '0;
    bus.i_sw  = '0;
    do_reset();
    check_out("reset", 8'h00, 3'b000, 1'b0, 2'b00);
    press(4'b1000, 8'h00);
    check_out("exec_in_idle", 8'h00, 3'b000, 1'b0, 2'b00);

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op);
      check_out(vecs[i].name, vecs[i].led, vecs[i].flags, 1'b1, 2'b11);
    end

    // Reload after a result clears valid and keeps the old LEDs
    run_op(8'h05, 8'h05, OP_SUB);
    check_out("sub_eq", 8'h00, 3'b001, 1'b1, 2'b11);
    press(4'b0001, 8'h03);
    check_out("reload_a", 8'h00, 3'b001, 1'b0, 2'b01);
    press(4'b1000, 8'h00);
    check_out("sub_reexec", 8'hFE, 3'b010, 1'b1, 2'b11);

    // Simultaneous btn0+btn1: only A is loaded
    run_op(8'h00, 8'h11, OP_ADD);
    press(4'b0011, 8'h3C);
    press(4'b1000, 8'h00);
    check_out("prio_a_over_b", 8'h4D, 3'b000, 1'b1, 2'b11);

    // Simultaneous btn2+btn3: opcode loaded, execute dropped
    press(4'b1100, {2'b00, OP_SUB});
    check_out("prio_op_over_exec", 8'h4D, 3'b000, 1'b0, 2'b01);
    press(4'b1000, 8'h00);
    check_out("prio_sub", 8'h2B, 3'b000, 1'b1, 2'b11);

    // Button held 50 cycles loads once; a later switch change is ignored
    run_op(8'h00, 8'h00, OP_ADD);
    @(posedge clock);
    #1 bus.i_sw = 8'h01; bus.i_btn = 4'b0001;
    repeat (20) @(posedge clock);
    #1 bus.i_sw = 8'h02;
    repeat (30) @(posedge clock);
    #1 bus.i_btn = '0;
    repeat (SETTLE) @(posedge clock);
    press(4'b1000, 8'h00);
    check_out("held_btn_one_load", 8'h01, 3'b000, 1'b1, 2'b11);

    // Bouncing btn0: 2-cycle toggles, then held high
    run_op(8'h00, 8'h00, OP_OR);
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      bus.i_sw  = 8'(8'h11 * (k + 1));
      bus.i_btn = 4'b0001;
      repeat (2) @(posedge clock);
      #1 bus.i_btn = '0;
      repeat (2) @(posedge clock);
      #1;
    end
    bus.i_sw  = 8'h44;
    bus.i_btn = 4'b0001;
    @(negedge clock);
`ifdef DEBOUNCE_EN
    check("bounce_filtered.state", 32'(bus.o_state), 32'd3);
    exp_a = 8'h0F;
`else
    check("bounce_loads.state", 32'(bus.o_state), 32'd1);
    exp_a = 8'h44;
`endif
    repeat (5) @(posedge clock);
    #1 bus.i_sw = 8'h0F;
    repeat (8) @(posedge clock);
    #1 bus.i_btn = '0;
    repeat (SETTLE) @(posedge clock);
    @(negedge clock);
    check("bounce_after.state", 32'(bus.o_state), 32'd1);
    press(4'b1000, 8'h00);
    check_out("bounce_value", exp_a, 3'b000, 1'b1, 2'b11);

    // EXEC lasts exactly one cycle; outputs change only when it ends
    run_op(8'h12, 8'h34, OP_ADD);
    press(4'b0001, 8'h20);
    @(posedge clock);
    #1 bus.i_btn = 4'b1000;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.o_state == 2'b10) begin found = 1; break; end
    end
    check("exec_seen", 32'(found), 32'd1);
    check_out("in_exec", 8'h46, 3'b000, 1'b0, 2'b10);
    @(negedge clock);
    check_out("after_exec", 8'h54, 3'b000, 1'b1, 2'b11);
    @(posedge clock);
    #1 bus.i_btn = '0;
    repeat (SETTLE) @(posedge clock);

    // Reset during EXEC wins and clears the operand registers
    press(4'b0001, 8'h77);
    @(posedge clock);
    #1 bus.i_btn = 4'b1000;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.o_state == 2'b10) begin found = 1; break; end
    end
    check("exec_seen_rst", 32'(found), 32'd1);
    i_reset   = 1'b1;
    bus.i_btn = '0;
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;
    @(negedge clock);
    check_out("rst_in_exec", 8'h00, 3'b000, 1'b0, 2'b00);
    press(4'b0100, {2'b00, OP_ADD});
    press(4'b1000, 8'h00);
    check_out("rst_cleared_ops", 8'h00, 3'b001, 1'b1, 2'b11);

    // Randomized commands against the operation-level model
    do_reset();
    m_a = 0; m_b = 0; m_op = 0; m_led = 0; m_flags = 3'b000; m_valid = 0; m_state = 0;
    for (int it = 0; it < 40; it++) begin
      int btn, sw, pick;
      logic [5:0] ops [8];
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
      btn = $urandom_range(0, 3);
      case (btn)
        0: sw = $urandom_range(0, 255);
        1: sw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 11) : $urandom_range(0, 255);
        2: begin
          pick = $urandom_range(0, 8);
          sw = (pick == 8) ? $urandom_range(0, 63) : 32'(ops[pick]);
        end
        default: sw = $urandom_range(0, 255);
      endcase
      press(4'(1 << btn), 8'(sw));
      model_cmd(btn, sw);
      check_out($sformatf("rand%0d", it), 8'(m_led), m_flags, m_valid, 2'(m_state));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
